// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART byte receiver, 8N1 LSB first, centre sampling; even parity with UART_RX_PARITY_EN
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 5120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RXD,
    input  logic       rx_en,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;
`endif

    state_t      state, state_n;
    logic        sync1, sync2, prev;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  shreg, shreg_n;
    logic [7:0]  data_n;
    logic        done_n, ferr_n;
    logic        stop_ok;

`ifdef UART_RX_PARITY_EN
    logic par_bad, par_bad_n;
    assign stop_ok = sync2 && !par_bad;
`else
    assign stop_ok = sync2;
`endif

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            prev      <= 1'b1;
            state     <= S_IDLE;
            cnt       <= 16'd0;
            idx       <= 3'd0;
            shreg     <= 8'h00;
            rx_data   <= 8'h00;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad   <= 1'b0;
`endif
        end else begin
            sync1     <= RXD;
            sync2     <= sync1;
            prev      <= sync2;
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shreg     <= shreg_n;
            rx_data   <= data_n;
            rx_done   <= done_n;
            frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
            par_bad   <= par_bad_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        data_n  = rx_data;
        done_n  = 1'b0;
        ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n = par_bad;
`endif
        case (state)
            S_IDLE: begin
                cnt_n = 16'd0;
                if (rx_en && !sync2 && prev) state_n = S_START;
            end
            S_START: begin
                // A line back high at half-bit means a glitch, not a start bit
                if (cnt == HALF_M1) begin
                    cnt_n   = 16'd0;
                    idx_n   = 3'd0;
                    state_n = sync2 ? S_IDLE : S_DATA;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (cnt == BIT_M1) begin
                    cnt_n          = 16'd0;
                    shreg_n[idx]   = sync2;
                    idx_n          = idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (idx == 3'd7) state_n = S_PARITY;
`else
                    if (idx == 3'd7) state_n = S_STOP;
`endif
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt == BIT_M1) begin
                    cnt_n     = 16'd0;
                    par_bad_n = (^shreg) ^ sync2;
                    state_n   = S_STOP;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
`endif
            S_STOP: begin
                // Leave at the stop-bit centre so a following start edge is not missed
                if (cnt == BIT_M1) begin
                    cnt_n = 16'd0;
                    if (stop_ok) begin
                        data_n  = shreg;
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = sync2 ? S_IDLE : S_WAIT_HIGH;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_WAIT_HIGH: begin
                if (sync2) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed bench for uart_rx_core at CLKS_PER_BIT=16
module tb_uart_rx_core;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif
    // Negedges from driving the start bit low to seeing the result pulse
    localparam int LAT = HALF + NBITS * CPB + 3;

    logic       clk = 1'b0;
    logic       reset, RXD, rx_en;
    logic [7:0] rx_data;
    logic       rx_done, frame_err, busy;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0, ferr_cnt = 0, busy_cnt = 0, both_cnt = 0;
    int last_done_cyc = 0, last_ferr_cyc = 0;
    int frame_start = 0;
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .RXD(RXD), .rx_en(rx_en),
        .rx_data(rx_data), .rx_done(rx_done), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_done === 1'b1) begin done_cnt++; last_done_cyc = cyc; end
        if (frame_err === 1'b1) begin ferr_cnt++; last_ferr_cyc = cyc; end
        if (busy === 1'b1) busy_cnt++;
        if (rx_done === 1'b1 && frame_err === 1'b1) both_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
        $fatal(1);
    end

    task automatic send_frame(input logic [7:0] d, input logic stop_val, input int stop_bits);
        RXD = 1'b0;
        frame_start = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RXD = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        RXD = (^d) ^ par_flip;
        repeat (CPB) @(negedge clk);
`endif
        RXD = stop_val;
        repeat (CPB * stop_bits) @(negedge clk);
        RXD = 1'b1;
    endtask

    task automatic test_reset();
        RXD = 1'b1; rx_en = 1'b1; reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got %h exp 00", rx_data); end
        n_cmp++; if (rx_done !== 1'b0) begin n_fail++; $display("FAIL reset_rx_done got %b exp 0", rx_done); end
        n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] pats [3];
        int d0, f0;
        pats = '{8'h33, 8'hA5, 8'h00};
        for (int p = 0; p < 3; p++) begin
            d0 = done_cnt; f0 = ferr_cnt;
            send_frame(pats[p], 1'b1, 1);
            repeat (2) @(negedge clk);
            n_cmp++; if (rx_data !== pats[p]) begin n_fail++; $display("FAIL basic_data got %h exp %h", rx_data, pats[p]); end
            n_cmp++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL basic_done_pulses got %0d exp 1", done_cnt - d0); end
            n_cmp++; if (last_done_cyc - frame_start !== LAT) begin n_fail++; $display("FAIL basic_latency got %0d exp %0d", last_done_cyc - frame_start, LAT); end
            n_cmp++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL basic_frame_err got %0d exp 0", ferr_cnt - f0); end
        end
    endtask

    task automatic test_back_to_back();
        int d0, f0, t;
        logic [7:0] got [2];
        d0 = done_cnt; f0 = ferr_cnt;
        got = '{8'h00, 8'h00};
        fork
            begin
                send_frame(8'h66, 1'b1, 1);
                send_frame(8'hAA, 1'b1, 1);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    t = 0;
                    while (rx_done !== 1'b1 && t < 400) begin @(negedge clk); t++; end
                    got[k] = rx_data;
                    rx_en = 1'b0;
                    @(negedge clk);
                    rx_en = 1'b1;
                end
            end
        join
        repeat (4) @(negedge clk);
        n_cmp++; if (done_cnt - d0 !== 2) begin n_fail++; $display("FAIL b2b_done_pulses got %0d exp 2", done_cnt - d0); end
        n_cmp++; if (got[0] !== 8'h66) begin n_fail++; $display("FAIL b2b_first got %h exp 66", got[0]); end
        n_cmp++; if (got[1] !== 8'hAA) begin n_fail++; $display("FAIL b2b_second got %h exp aa", got[1]); end
        n_cmp++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL b2b_frame_err got %0d exp 0", ferr_cnt - f0); end
    endtask

    task automatic test_glitch();
        int d0, f0;
        d0 = done_cnt; f0 = ferr_cnt;
        RXD = 1'b0;
        repeat (5) @(negedge clk);
        RXD = 1'b1;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_high got %b exp 1", busy); end
        repeat (8) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_low got %b exp 0", busy); end
        repeat (2 * CPB) @(negedge clk);
        n_cmp++; if (done_cnt - d0 + ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL glitch_pulses got %0d exp 0", done_cnt - d0 + ferr_cnt - f0); end
    endtask

    task automatic test_frame_err();
        int d0, f0;
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h88, 1'b0, 3);
        n_cmp++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_pulses got %0d exp 1", ferr_cnt - f0); end
        n_cmp++; if (last_ferr_cyc - frame_start !== LAT) begin n_fail++; $display("FAIL ferr_latency got %0d exp %0d", last_ferr_cyc - frame_start, LAT); end
        n_cmp++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL ferr_no_done got %0d exp 0", done_cnt - d0); end
        n_cmp++; if (rx_data !== 8'hAA) begin n_fail++; $display("FAIL ferr_rx_data got %h exp aa", rx_data); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_while_low got %b exp 1", busy); end
        repeat (4) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_after_high got %b exp 0", busy); end
        repeat (CPB) @(negedge clk);
    endtask

    task automatic test_rx_disabled();
        int d0, f0, b0;
        d0 = done_cnt; f0 = ferr_cnt; b0 = busy_cnt;
        rx_en = 1'b0;
        send_frame(8'h33, 1'b1, 1);
        repeat (4) @(negedge clk);
        rx_en = 1'b1;
        n_cmp++; if (done_cnt - d0 + ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL disabled_pulses got %0d exp 0", done_cnt - d0 + ferr_cnt - f0); end
        n_cmp++; if (busy_cnt - b0 !== 0) begin n_fail++; $display("FAIL disabled_busy_cycles got %0d exp 0", busy_cnt - b0); end
        n_cmp++; if (rx_data !== 8'hAA) begin n_fail++; $display("FAIL disabled_rx_data got %h exp aa", rx_data); end
    endtask

    task automatic test_reset_mid_frame();
        int d0, f0;
        logic [7:0] b;
        b = 8'h66;
        RXD = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RXD = b[i];
            repeat (CPB) @(negedge clk);
        end
        d0 = done_cnt; f0 = ferr_cnt;
        reset = 1'b1; RXD = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midreset_rx_data got %h exp 00", rx_data); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b exp 0", busy); end
        repeat (2 * CPB) @(negedge clk);
        n_cmp++; if (done_cnt - d0 + ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL midreset_pulses got %0d exp 0", done_cnt - d0 + ferr_cnt - f0); end
        d0 = done_cnt;
        send_frame(8'h88, 1'b1, 1);
        repeat (2) @(negedge clk);
        n_cmp++; if (rx_data !== 8'h88) begin n_fail++; $display("FAIL midreset_next_data got %h exp 88", rx_data); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL midreset_next_done got %0d exp 1", done_cnt - d0); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int d0, f0;
        d0 = done_cnt; f0 = ferr_cnt;
        par_flip = 1'b0;
        send_frame(8'h33, 1'b1, 1);
        repeat (2) @(negedge clk);
        n_cmp++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL parity_good_done got %0d exp 1", done_cnt - d0); end
        n_cmp++; if (rx_data !== 8'h33) begin n_fail++; $display("FAIL parity_good_data got %h exp 33", rx_data); end
        d0 = done_cnt;
        par_flip = 1'b1;
        send_frame(8'h3C, 1'b1, 1);
        par_flip = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL parity_bad_ferr got %0d exp 1", ferr_cnt - f0); end
        n_cmp++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL parity_bad_done got %0d exp 0", done_cnt - d0); end
        n_cmp++; if (rx_data !== 8'h33) begin n_fail++; $display("FAIL parity_bad_data got %h exp 33", rx_data); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_rx_disabled();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        n_cmp++; if (both_cnt !== 0) begin n_fail++; $display("FAIL done_and_ferr_together got %0d exp 0", both_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
